// File: rtl/cpu_flagreg.sv
// Processor flag register with sticky flags and a small save/restore stack.
// Optional macro CPU_FLAGREG_FWD_EN makes FLAGS_FWD present the next-state flags combinationally.
module cpu_flagreg #(
    parameter int                 NFLAGS      = 3,
    parameter int                 DEPTH       = 4,
    parameter logic [NFLAGS-1:0]  STICKY_MASK = NFLAGS'(2)
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [NFLAGS-1:0]         FLAG_IN,
    input  logic [NFLAGS-1:0]         FLAG_WE,
    input  logic                      CLR,
    input  logic                      PUSH,
    input  logic                      POP,
    input  logic                      ERR_CLR,
    output logic [NFLAGS-1:0]         FLAGS,
    output logic [NFLAGS-1:0]         FLAGS_FWD,
    output logic [$clog2(DEPTH):0]    LEVEL,
    output logic                      FULL,
    output logic                      EMPTY,
    output logic                      ERR
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [NFLAGS-1:0] flags_q;
    logic [NFLAGS-1:0] flags_nxt;
    logic [LW-1:0]     level_q;
    logic              err_q;
    logic [NFLAGS-1:0] stack_mem [DEPTH];

    logic              full;
    logic              empty;
    logic              push_ok;
    logic              pop_ok;
    logic              err_evt;
    logic [AW-1:0]     wr_idx;
    logic [AW-1:0]     rd_idx;

    assign full  = (level_q == LW'(DEPTH));
    assign empty = (level_q == '0);

    // PUSH together with POP cancels both without flagging an error.
    assign push_ok = PUSH & ~POP & ~full;
    assign pop_ok  = POP & ~PUSH & ~empty;
    assign err_evt = (PUSH & ~POP & full) | (POP & ~PUSH & empty);

    // When full, the low bits wrap to 0, so rd_idx still lands on DEPTH-1.
    assign wr_idx = level_q[AW-1:0];
    assign rd_idx = level_q[AW-1:0] - AW'(1);

    always_comb begin
        flags_nxt = flags_q;
        if (pop_ok) begin
            flags_nxt = stack_mem[rd_idx];
        end else if (CLR) begin
            flags_nxt = '0;
        end else begin
            for (int i = 0; i < NFLAGS; i++) begin
                if (FLAG_WE[i]) begin
                    flags_nxt[i] = STICKY_MASK[i] ? (flags_q[i] | FLAG_IN[i]) : FLAG_IN[i];
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            flags_q <= '0;
            level_q <= '0;
            err_q   <= 1'b0;
        end else begin
            flags_q <= flags_nxt;
            if (push_ok) begin
                level_q <= level_q + LW'(1);
            end else if (pop_ok) begin
                level_q <= level_q - LW'(1);
            end
            if (err_evt) begin
                err_q <= 1'b1;
            end else if (ERR_CLR) begin
                err_q <= 1'b0;
            end
        end
    end

    // Stack storage is not reset; LEVEL alone defines which entries are valid.
    always_ff @(posedge CLK) begin
        if (!RST && push_ok) begin
            stack_mem[wr_idx] <= flags_q;
        end
    end

`ifdef CPU_FLAGREG_FWD_EN
    assign FLAGS_FWD = RST ? '0 : flags_nxt;
`else
    assign FLAGS_FWD = flags_q;
`endif

    assign FLAGS = flags_q;
    assign LEVEL = level_q;
    assign FULL  = full;
    assign EMPTY = empty;
    assign ERR   = err_q;

endmodule

// File: tb/tb_cpu_flagreg.sv
// Directed self-checking bench for cpu_flagreg (NFLAGS=3, DEPTH=4, Z sticky).
module tb_cpu_flagreg;

    logic       CLK = 1'b0;
    logic       RST;
    logic [2:0] FLAG_IN;
    logic [2:0] FLAG_WE;
    logic       CLR;
    logic       PUSH;
    logic       POP;
    logic       ERR_CLR;
    logic [2:0] FLAGS;
    logic [2:0] FLAGS_FWD;
    logic [2:0] LEVEL;
    logic       FULL;
    logic       EMPTY;
    logic       ERR;

    int n_cmp = 0;
    int n_err = 0;

    cpu_flagreg #(.NFLAGS(3), .DEPTH(4), .STICKY_MASK(3'b010)) dut (
        .CLK(CLK), .RST(RST), .FLAG_IN(FLAG_IN), .FLAG_WE(FLAG_WE), .CLR(CLR),
        .PUSH(PUSH), .POP(POP), .ERR_CLR(ERR_CLR), .FLAGS(FLAGS), .FLAGS_FWD(FLAGS_FWD),
        .LEVEL(LEVEL), .FULL(FULL), .EMPTY(EMPTY), .ERR(ERR)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        RST = 0; FLAG_IN = 3'b000; FLAG_WE = 3'b000; CLR = 0; PUSH = 0; POP = 0; ERR_CLR = 0;
    endtask

    logic [2:0] push_in [5];

    initial begin
        idle();
        RST = 1;
        step();
        chk("rst_flags", FLAGS, 3'b000);
        chk("rst_level", LEVEL, 3'd0);
        chk("rst_empty", EMPTY, 1'b1);
        chk("rst_full", FULL, 1'b0);
        chk("rst_err", ERR, 1'b0);

        // Sticky Z accumulates, CLR lowers it
        idle(); FLAG_WE = 3'b111; FLAG_IN = 3'b111;
        step();
        chk("all_set", FLAGS, 3'b111);
        FLAG_IN = 3'b000;
        step();
        chk("sticky_z", FLAGS, 3'b010);
        FLAG_WE = 3'b000; FLAG_IN = 3'b111;
        step();
        chk("we0_hold", FLAGS, 3'b010);
        CLR = 1; FLAG_WE = 3'b111;
        step();
        chk("clr", FLAGS, 3'b000);

        // Save / restore round trip
        idle(); FLAG_WE = 3'b111; FLAG_IN = 3'b101;
        step();
        chk("load_101", FLAGS, 3'b101);
        idle(); PUSH = 1;
        step();
        chk("push_level", LEVEL, 3'd1);
        idle(); FLAG_WE = 3'b111; FLAG_IN = 3'b000;
        step();
        chk("overwrite", FLAGS, 3'b000);
        idle(); POP = 1;
        step();
        chk("pop_flags", FLAGS, 3'b101);
        chk("pop_level", LEVEL, 3'd0);
        chk("pop_empty", EMPTY, 1'b1);

        // Push stores pre-edge value while flags update; pop next cycle beats CLR
        idle(); PUSH = 1; FLAG_WE = 3'b111; FLAG_IN = 3'b010;
        step();
        chk("push_upd", FLAGS, 3'b010);
        idle(); POP = 1; CLR = 1;
        step();
        chk("pop_over_clr", FLAGS, 3'b101);
        chk("pop_over_clr_lvl", LEVEL, 3'd0);

        // Underflow: restore suppressed, FLAG_WE still applies
        idle(); RST = 1;
        step();
        idle(); POP = 1; FLAG_WE = 3'b001; FLAG_IN = 3'b001;
        step();
        chk("uflow_flags", FLAGS, 3'b001);
        chk("uflow_err", ERR, 1'b1);
        chk("uflow_level", LEVEL, 3'd0);
        idle(); ERR_CLR = 1;
        step();
        chk("errclr", ERR, 1'b0);
        idle(); ERR_CLR = 1; POP = 1;
        step();
        chk("err_beats_clr", ERR, 1'b1);
        idle(); ERR_CLR = 1;
        step();
        chk("errclr2", ERR, 1'b0);

        // Fill the stack with distinct values, then overflow
        idle(); RST = 1;
        step();
        push_in[0] = 3'b001; push_in[1] = 3'b100; push_in[2] = 3'b101;
        push_in[3] = 3'b000; push_in[4] = 3'b001;
        for (int k = 0; k < 5; k++) begin
            idle(); PUSH = 1; FLAG_WE = 3'b101; FLAG_IN = push_in[k];
            step();
            chk("fill_flags", FLAGS, push_in[k]);
            chk("fill_level", LEVEL, (k < 4) ? 3'(k + 1) : 3'd4);
            chk("fill_err", ERR, (k == 4) ? 1'b1 : 1'b0);
        end
        chk("full", FULL, 1'b1);
        idle(); ERR_CLR = 1;
        step();
        chk("ovf_errclr", ERR, 1'b0);
        chk("ovf_level", LEVEL, 3'd4);

        // LIFO order: stored 000,001,100,101 bottom to top
        idle(); POP = 1;
        step();
        chk("lifo_3", FLAGS, 3'b101);
        chk("lifo_3_full", FULL, 1'b0);
        step();
        chk("lifo_2", FLAGS, 3'b100);
        chk("lifo_2_lvl", LEVEL, 3'd2);

        // PUSH+POP together is a no-op on the stack
        idle(); PUSH = 1; POP = 1; FLAG_WE = 3'b001; FLAG_IN = 3'b001;
        step();
        chk("pp_level", LEVEL, 3'd2);
        chk("pp_err", ERR, 1'b0);
        chk("pp_flags", FLAGS, 3'b101);
        idle(); POP = 1;
        step();
        chk("lifo_1", FLAGS, 3'b001);

        // Reset overrides push mid-sequence
        idle(); RST = 1; PUSH = 1; FLAG_WE = 3'b111; FLAG_IN = 3'b111;
        step();
        chk("rst_push_lvl", LEVEL, 3'd0);
        chk("rst_push_flags", FLAGS, 3'b000);
        chk("rst_push_empty", EMPTY, 1'b1);

        // Forwarded value before and after the edge
        idle(); FLAG_WE = 3'b001; FLAG_IN = 3'b001;
        #1;
`ifdef CPU_FLAGREG_FWD_EN
        chk("fwd_pre", FLAGS_FWD, 3'b001);
`else
        chk("fwd_pre", FLAGS_FWD, 3'b000);
`endif
        chk("fwd_pre_flags", FLAGS, 3'b000);
        step();
        chk("fwd_post_flags", FLAGS, 3'b001);
        idle();
        #1;
        chk("fwd_post", FLAGS_FWD, 3'b001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
